// File: rtl/song_reader_pkg.sv
// rtl/song_reader_pkg.sv - shared widths, end marker and state encoding for the song sequencer
package song_reader_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;
  localparam int ROM_AW = SONG_W + IDX_W;
  localparam int ROM_DW = NOTE_W + DUR_W;

  // A zero duration marks the end of a song shorter than the full table.
  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_FETCH   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/song_reader_if.sv
// rtl/song_reader_if.sv - play/song controls and note player handshake
interface song_reader_if;
  import song_reader_pkg::*;

  logic              play;
  logic [SONG_W-1:0] song;
  logic              note_done;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  modport master (
    input  play, song, note_done,
    output note, duration, new_note, song_done
  );

  modport slave (
    output play, song, note_done,
    input  note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_reader_dffr.sv
// rtl/song_reader_dffr.sv - parameterised flop with asynchronous active-high clear
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/song_reader_rom.sv
// rtl/song_reader_rom.sv - synchronous 128 x 12 song table, dout = {note, duration}
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] dout
);

  logic [IDX_W-1:0]  idx;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign idx = addr[IDX_W-1:0];

  // Song 0 and 2 fill all entries, song 1 ends at entry 3, song 3 at entry 1.
  always_comb begin
    rom_note = '0;
    rom_dur  = '0;
    case (addr[ROM_AW-1:IDX_W])
      2'd0: begin
        rom_note = 6'd20 + NOTE_W'(idx);
        rom_dur  = 6'd12 + DUR_W'(idx);
      end
      2'd1: begin
        case (idx)
          5'd0: begin rom_note = 6'd30; rom_dur = 6'd5; end
          5'd1: begin rom_note = 6'd0;  rom_dur = 6'd6; end
          5'd2: begin rom_note = 6'd32; rom_dur = 6'd7; end
          default: ;
        endcase
      end
      2'd2: begin
        rom_note = 6'd40 + {2'b00, idx[3:0]};
        rom_dur  = 6'd3;
      end
      2'd3: begin
        if (idx == '0) begin
          rom_note = 6'd63;
          rom_dur  = 6'd63;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    dout <= {rom_note, rom_dur};
  end

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - steps through a stored song, handing one note at a time to the note player
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NOTES_PER_SONG = 32,
  parameter int NUM_SONGS      = 4
) (
  input  logic         clk,
  input  logic         reset,
  song_reader_if.master bus
);

  localparam int               SONG_BITS = $clog2(NUM_SONGS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NOTES_PER_SONG - 1);

  state_t            st, st_d;
  logic [2:0]        st_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SONG_W-1:0] song_q, song_d, song_in;
  logic [NOTE_W-1:0] note_q, note_d, rom_note;
  logic [DUR_W-1:0]  dur_q, dur_d, rom_dur;
  logic              guard_q, guard_d;
  logic              song_change;
  logic [ROM_DW-1:0] rom_dout;

  assign song_in = SONG_W'(bus.song[SONG_BITS-1:0]);
  assign st      = state_t'(st_q);

  dffr #(.W(3))      u_state (.clk(clk), .reset(reset), .d(st_d),    .q(st_q));
  dffr #(.W(IDX_W))  u_idx   (.clk(clk), .reset(reset), .d(idx_d),   .q(idx_q));
  dffr #(.W(SONG_W)) u_song  (.clk(clk), .reset(reset), .d(song_d),  .q(song_q));
  dffr #(.W(NOTE_W)) u_note  (.clk(clk), .reset(reset), .d(note_d),  .q(note_q));
  dffr #(.W(DUR_W))  u_dur   (.clk(clk), .reset(reset), .d(dur_d),   .q(dur_q));
  dffr #(.W(1))      u_guard (.clk(clk), .reset(reset), .d(guard_d), .q(guard_q));

  // The ROM is addressed with next-cycle song/index so its data lands in FETCH.
  song_rom u_rom (
    .clk  (clk),
    .addr ({song_d, idx_d}),
    .dout (rom_dout)
  );

  assign rom_note = rom_dout[ROM_DW-1:DUR_W];
  assign rom_dur  = rom_dout[DUR_W-1:0];

  assign song_change = (st != ST_IDLE) && (song_in != song_q);

  always_comb begin
    st_d    = st;
    idx_d   = idx_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;
    guard_d = (st == ST_LOAD);
    if (song_change) begin
      st_d  = ST_IDLE;
      idx_d = '0;
    end else begin
      case (st)
        ST_IDLE: begin
          idx_d = '0;
          if (bus.play && bus.note_done) begin
            st_d   = ST_FETCH;
            song_d = song_in;
          end
        end
        ST_FETCH: begin
          if (rom_dur == END_DUR) begin
            st_d = ST_DONE;
          end else begin
            note_d = rom_note;
            dur_d  = rom_dur;
            st_d   = ST_LOAD;
          end
        end
        ST_LOAD: st_d = ST_WAIT;
        ST_WAIT: begin
          // guard_q blocks the note_done still held from the previous note.
          if (!guard_q && bus.play && bus.note_done) st_d = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          idx_d = idx_q + IDX_W'(1);
          st_d  = (idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          idx_d = '0;
          st_d  = ST_IDLE;
        end
        default: begin
          idx_d = '0;
          st_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.new_note  = 1'b0;
    bus.song_done = 1'b0;
    case (st)
      ST_LOAD: bus.new_note  = 1'b1;
      ST_DONE: bus.song_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.note     = note_q;
  assign bus.duration = dur_q;

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - scoreboard bench for song_reader
module tb_song_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   loads = 0;
  int   dones = 0;
  logic [11:0] exp_q[$];

  song_reader_if bus();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_entry(input int s, input int i);
    logic [5:0] n;
    logic [5:0] d;
    n = 6'd0;
    d = 6'd0;
    case (s)
      0: begin n = 6'(20 + i); d = 6'(12 + i); end
      1: begin
        if (i == 0)      begin n = 6'd30; d = 6'd5; end
        else if (i == 1) begin n = 6'd0;  d = 6'd6; end
        else if (i == 2) begin n = 6'd32; d = 6'd7; end
      end
      2: begin n = 6'(40 + (i % 16)); d = 6'd3; end
      default: if (i == 0) begin n = 6'd63; d = 6'd63; end
    endcase
    return {n, d};
  endfunction

  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset && bus.new_note) begin
      loads++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_load note=%0d duration=%0d required none", bus.note, bus.duration);
      end else begin
        e = exp_q.pop_front();
        if ({bus.note, bus.duration} !== e) begin
          errors++;
          $display("FAIL sb_load note=%0d duration=%0d required note=%0d duration=%0d",
                   bus.note, bus.duration, e[11:6], e[5:0]);
        end
      end
    end
    if (!reset && bus.song_done) dones++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.play = 1'b0;
    bus.note_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_until_done(input int limit, output bit seen, output int gap);
    int last;
    last = -100;
    seen = 1'b0;
    gap = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.new_note) last = c;
      if (bus.song_done) begin
        seen = 1'b1;
        gap = c - last;
        bus.play = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.play = 1'b0;
    bus.note_done = 1'b0;
    bus.song = 2'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.note, bus.duration, bus.new_note, bus.song_done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {bus.note, bus.duration, bus.new_note, bus.song_done});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (loads !== 0) begin
      errors++;
      $display("FAIL idle_no_load loads=%0d required=0", loads);
    end
  endtask

  task automatic test_first_note();
    @(negedge clk);
    bus.song = 2'd0;
    bus.play = 1'b1;
    bus.note_done = 1'b1;
    exp_q.push_back(exp_entry(0, 0));
    @(posedge clk);
    #1;
    checks++;
    if (bus.new_note !== 1'b0) begin
      errors++;
      $display("FAIL start_early new_note=%b required=0", bus.new_note);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.new_note, bus.note, bus.duration, bus.song_done} !== {1'b1, 6'd20, 6'd12, 1'b0}) begin
      errors++;
      $display("FAIL start_load new_note=%b note=%0d duration=%0d song_done=%b required 1 20 12 0",
               bus.new_note, bus.note, bus.duration, bus.song_done);
    end
    @(negedge clk);
    bus.note_done = 1'b0;
  endtask

  task automatic test_pause();
    int n;
    n = 0;
    @(negedge clk);
    bus.play = 1'b0;
    bus.note_done = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.new_note) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL pause_hold loads=%0d required=0", n);
    end
    exp_q.push_back(exp_entry(0, 1));
    bus.play = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.new_note) n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if ({n[1:0], bus.new_note, bus.note, bus.duration} !== {2'd0, 1'b1, 6'd21, 6'd13}) begin
      errors++;
      $display("FAIL resume_load early=%0d new_note=%b note=%0d duration=%0d required 0 1 21 13",
               n, bus.new_note, bus.note, bus.duration);
    end
    @(negedge clk);
    bus.note_done = 1'b0;
  endtask

  task automatic test_reset_in_fetch();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    bus.note_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.note_done = 1'b0;
    #1;
    checks++;
    if ({bus.note, bus.duration, bus.new_note, bus.song_done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_async got=%h required=0", {bus.note, bus.duration, bus.new_note, bus.song_done});
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.new_note) n++;
    end
    reset = 1'b0;
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_no_load loads=%0d required=0", n);
    end
    exp_q.push_back(exp_entry(0, 0));
    bus.note_done = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.new_note) begin
        got = 1'b1;
        bus.note_done = 1'b0;
        checks++;
        if (bus.note !== 6'd20) begin
          errors++;
          $display("FAIL reset_restart note=%0d required=20", bus.note);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_restart_timeout loaded=%b required=1", got);
    end
  endtask

  task automatic test_song_change();
    int n;
    int d0;
    n = 0;
    do_reset();
    d0 = dones;
    bus.song = 2'd0;
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_entry(0, i));
    bus.play = 1'b1;
    bus.note_done = 1'b1;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (bus.new_note) n++;
    end
    bus.note_done = 1'b0;
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL change_setup loads=%0d required=6", n);
    end
    @(negedge clk);
    bus.song = 2'd2;
    bus.note_done = 1'b1;
    exp_q.push_back(exp_entry(2, 0));
    @(posedge clk);
    #1;
    checks++;
    if ({bus.note, bus.duration, bus.new_note, bus.song_done} !== {6'd25, 6'd17, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL change_retain note=%0d duration=%0d new_note=%b song_done=%b required 25 17 0 0",
               bus.note, bus.duration, bus.new_note, bus.song_done);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.new_note, bus.note, bus.duration} !== {1'b1, 6'd40, 6'd3}) begin
      errors++;
      $display("FAIL change_restart new_note=%b note=%0d duration=%0d required 1 40 3",
               bus.new_note, bus.note, bus.duration);
    end
    @(negedge clk);
    bus.note_done = 1'b0;
    checks++;
    if (dones !== d0) begin
      errors++;
      $display("FAIL change_no_done dones=%0d required=%0d", dones, d0);
    end
  endtask

  task automatic test_song(input int s, input int len, input int exp_gap, input int limit);
    bit seen;
    int gap;
    int l0;
    do_reset();
    l0 = loads;
    bus.song = 2'(s);
    for (int i = 0; i < len; i++) exp_q.push_back(exp_entry(s, i));
    bus.play = 1'b1;
    bus.note_done = 1'b1;
    run_until_done(limit, seen, gap);
    checks++;
    if (!seen || gap !== exp_gap) begin
      errors++;
      $display("FAIL song%0d_done seen=%b gap=%0d required seen=1 gap=%0d", s, seen, gap, exp_gap);
    end
    @(negedge clk);
    checks++;
    if (bus.song_done !== 1'b0) begin
      errors++;
      $display("FAIL song%0d_done_width song_done=%b required=0", s, bus.song_done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (loads - l0 !== len || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL song%0d_count loads=%0d pending=%0d required loads=%0d pending=0",
               s, loads - l0, exp_q.size(), len);
    end
  endtask

  task automatic test_replay();
    bit got;
    got = 1'b0;
    exp_q.push_back(exp_entry(0, 0));
    bus.play = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.new_note) begin
        got = 1'b1;
        bus.note_done = 1'b0;
      end
    end
    checks++;
    if (!got || bus.note !== 6'd20) begin
      errors++;
      $display("FAIL replay_entry0 loaded=%b note=%0d required 1 20", got, bus.note);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_note();
    test_pause();
    test_reset_in_fetch();
    test_song_change();
    test_song(1, 3, 5, 200);
    test_song(3, 1, 5, 100);
    test_song(0, 32, 4, 1000);
    test_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
